// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle MIPS div/divu sequencer.
// A WIDTH-iteration restoring division runs on the operand magnitudes. The
// MIPS sign rules are applied afterwards: the quotient is negative when the
// operand signs differ, and the remainder takes the sign of the dividend.
// The stall output holds the pipeline while a divide is in flight.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start                  divide request, sampled in IDLE/DONE only
//   signed_op              1 = div (two's complement), 0 = divu
//   dividend, divisor      rs / rt operands, sampled with start
//   busy                   high in RUN and FIXUP
//   stall                  busy | (start & ~busy)
//   done                   one-cycle pulse in DONE
//   quotient, remainder    LO / HI results, held until the next accepted start
//   div_by_zero            flag for the last result, held like the results
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t           state;
  logic             sq;
  logic             sr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] b_mag;
  logic [CW-1:0]    cnt;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;
  logic [WIDTH:0]   r_shift;
  logic             take;
  logic [WIDTH-1:0] r_sub;

  // The remainder held between iterations is always below |b|, so WIDTH bits
  // suffice for storage. Only the shifted trial value needs the extra bit; if
  // that bit is set the trial value certainly exceeds |b|, and the true
  // difference then still fits in WIDTH bits, so a modular WIDTH-bit subtract
  // is exact.
  always_comb begin
    a_neg    = signed_op & dividend[WIDTH-1];
    b_neg    = signed_op & divisor[WIDTH-1];
    a_mag_in = a_neg ? -dividend : dividend;
    b_mag_in = b_neg ? -divisor : divisor;
    r_shift  = {r, q[WIDTH-1]};
    take     = r_shift[WIDTH] | (r_shift[WIDTH-1:0] >= b_mag);
    r_sub    = r_shift[WIDTH-1:0] - b_mag;
  end

  assign stall = busy | (start & ~busy);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      sq          <= 1'b0;
      sr          <= 1'b0;
      q           <= '0;
      r           <= '0;
      b_mag       <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            sq    <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sr    <= signed_op & dividend[WIDTH-1];
            q     <= a_mag_in;
            b_mag <= b_mag_in;
            r     <= '0;
            cnt   <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              state       <= S_DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= S_RUN;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
          end
        end

        S_RUN: begin
          r <= take ? r_sub : r_shift[WIDTH-1:0];
          q <= {q[WIDTH-2:0], take};
          if (cnt == '0) begin
            state <= S_FIXUP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        S_FIXUP: begin
          quotient  <= sq ? -q : q;
          remainder <= sr ? -r : r;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= S_DONE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer (WIDTH = 32). Expected results come
// from 64-bit integer arithmetic, which already follows the MIPS sign rules
// (truncating quotient, remainder signed like the dividend).
module tb_div_sequencer;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [W-1:0] exp_q;
  logic [W-1:0] exp_r;
  logic         exp_z;

  div_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference model: MIPS div/divu result from plain integer arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint sa, sb, qq, rr;
    if (b == '0) begin
      exp_q = '1;
      exp_r = a;
      exp_z = 1'b1;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
      end
      qq = sa / sb;
      rr = sa % sb;
      exp_q = qq[W-1:0];
      exp_r = rr[W-1:0];
      exp_z = 1'b0;
    end
  endtask

  // Called just after a clock edge: presents a request and checks the
  // issue-cycle stall.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    model(a, b, s);
    #1;
    check_eq("stall_issue", {63'b0, stall}, 64'd1);
  endtask

  // Waits for done (bounded), checking latency, busy length and results.
  // inject_at > 0 pulses start with fresh operands in that cycle of the run.
  task automatic finish_op(input string tag, input int inject_at);
    int  cyc;
    int  busy_cnt;
    bit  seen;
    cyc = 0;
    busy_cnt = 0;
    seen = 0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (inject_at > 0 && cyc == inject_at) begin
        dividend  = $urandom;
        divisor   = $urandom | 32'd1;
        signed_op = 1'($urandom);
        start     = 1'b1;
      end
      if (inject_at > 0 && cyc == inject_at + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) seen = 1;
    end
    check_eq({tag, "_seen"}, {63'b0, seen}, 64'd1);
    check_eq({tag, "_lat"}, 64'(cyc), exp_z ? 64'd1 : 64'(W + 2));
    check_eq({tag, "_busy"}, 64'(busy_cnt), exp_z ? 64'd0 : 64'(W + 1));
    check_eq({tag, "_q"}, {32'b0, quotient}, {32'b0, exp_q});
    check_eq({tag, "_r"}, {32'b0, remainder}, {32'b0, exp_r});
    check_eq({tag, "_dbz"}, {63'b0, div_by_zero}, {63'b0, exp_z});
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_drop"}, {63'b0, done}, 64'd0);
    check_eq({tag, "_hold"}, {quotient, remainder}, {exp_q, exp_r});
  endtask

  initial begin
    int dpulse;
    logic [W-1:0] a, b;
    logic s;

    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", {59'b0, busy, done, div_by_zero, stall, |quotient | |remainder}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    launch(32'd100, 32'd7, 1'b0);                 finish_op("u100_7", 0);      idle_cycle("u100_7");
    launch(32'hFFFF_FFF9, 32'd2, 1'b1);           finish_op("sm7_2", 0);       idle_cycle("sm7_2");
    launch(32'd7, 32'hFFFF_FFFE, 1'b1);           finish_op("s7_m2", 0);       idle_cycle("s7_m2");
    launch(32'h1234_5678, 32'd0, 1'b0);           finish_op("dbz", 0);         idle_cycle("dbz");
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);   finish_op("s_ovf", 0);       idle_cycle("s_ovf");
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);   finish_op("u_ext", 0);       idle_cycle("u_ext");
    launch(32'd1000, 32'd33, 1'b0);               finish_op("inject", 10);     idle_cycle("inject");

    // Back-to-back: second start presented in the DONE cycle.
    launch(32'd12345, 32'd10, 1'b0);              finish_op("b2b_first", 0);
    launch(32'hFFFF_0000, 32'd77, 1'b1);          finish_op("b2b_second", 0);
    launch(32'd9, 32'd0, 1'b1);                   finish_op("b2b_dbz", 0);
    launch(32'd9, 32'd0, 1'b0);                   finish_op("b2b_dbz2", 0);  idle_cycle("b2b");

    // Reset mid-operation.
    launch(32'd5000, 32'd3, 1'b0);
    dpulse = 0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 1'b0;
      if (done) dpulse++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_mid_outs", {59'b0, busy, done, div_by_zero, stall, |quotient | |remainder}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) dpulse++;
    end
    check_eq("rst_no_done", 64'(dpulse), 64'd0);
    launch(32'd5000, 32'd3, 1'b0);                finish_op("after_rst", 0);   idle_cycle("after_rst");

    // Randomized operations.
    for (int i = 0; i < 150; i++) begin
      case ($urandom % 8)
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      a = (($urandom % 10) == 0) ? 32'h8000_0000 : 32'($urandom);
      s = 1'($urandom);
      launch(a, b, s);
      finish_op("rand", 0);
      if (($urandom % 2) == 0) idle_cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the integer divide operation of the MIPS datapath. Accepts a divide request from the execute stage, performs a WIDTH-iteration restoring division on operand magnitudes, applies MIPS `div`/`divu` sign rules, and returns quotient (LO) and remainder (HI) with a one-cycle done pulse. Drives a stall to the pipeline hazard logic while the division is in flight, so that the single-cycle ALU path is not used for divide.

## Interface
- `WIDTH`, default 32: operand and result width in bits. Must be at least 2.
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset. Synchronous and active-low.
- `start`, input, 1: divide request. Sampled only in IDLE or DONE.
- `signed_op`, input, 1: 1 selects `div` (two's complement), 0 selects `divu`. Sampled with `start`.
- `dividend`, input, WIDTH: rs operand. Sampled with `start`.
- `divisor`, input, WIDTH: rt operand. Sampled with `start`.
- `busy`, output, 1: high in the RUN and FIXUP states.
- `stall`, output, 1: combinational `busy | (start & ~busy)`. Holds the pipeline from the issue cycle through the last FIXUP cycle.
- `done`, output, 1: one-cycle pulse in the DONE state.
- `quotient`, output, WIDTH: LO result. Held until the next accepted start.
- `remainder`, output, WIDTH: HI result. Held until the next accepted start.
- `div_by_zero`, output, 1: flag for the last result. Held like the result outputs.

## Operation
- States: IDLE, RUN, FIXUP, DONE.
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - `busy`, `done`, `div_by_zero`, `quotient` and `remainder` go to 0.
  - An operation in progress is aborted and no `done` is produced.
- IDLE or DONE with `start`=1:
  - Latch sign flags: `sq = signed_op & (a[MSB] ^ b[MSB])` and `sr = signed_op & a[MSB]`.
  - Latch magnitudes: `|a|` and `|b|` when `signed_op`=1, otherwise the raw operands.
  - Clear the partial remainder (WIDTH+1 bits). Load the iteration counter with WIDTH-1.
  - If divisor = 0: go to DONE. Set `quotient` = all ones, `remainder` = raw dividend, `div_by_zero` = 1.
  - Otherwise: go to RUN and set `div_by_zero` = 0.
- IDLE or DONE with `start`=0: go to or stay in IDLE.
- RUN, one quotient bit per cycle:
  - `r = {r[WIDTH-1:0], q[MSB]}` and `q = q << 1`.
  - If `r >= |b|`: `r = r - |b|` and `q[0] = 1`.
  - When the counter reaches 0, go to FIXUP. Otherwise decrement the counter.
- FIXUP:
  - Write `quotient` = `sq ? -q : q` and `remainder` = `sr ? -r : r`, both truncated to WIDTH.
  - Go to DONE.
- `start` while `busy` is ignored. The operands are not re-sampled.
- Signed overflow (most-negative / -1) is not special-cased. The magnitude arithmetic gives `quotient` = most-negative value and `remainder` = 0.
- Magnitude of the most-negative value is 2^(WIDTH-1). It is represented unsigned in WIDTH bits without loss.

## Timing
- Normal divide, with `start` accepted at edge T:
  - RUN occupies cycles T+1 .. T+WIDTH.
  - FIXUP occupies cycle T+WIDTH+1.
  - DONE occupies cycle T+WIDTH+2. `done`=1 and the results are valid in that cycle.
  - Latency is WIDTH+2 cycles (34 for WIDTH=32).
- Divide by zero: `done` is high in cycle T+1 (latency 1). `busy` never rises.
- `busy` is high in cycles T+1 .. T+WIDTH+1.
- `stall` is also high in cycle T, because the issue cycle is counted.
- `done` is high for exactly one cycle per accepted start.
- Back-to-back operation: a `start` in the DONE cycle is accepted. The next RUN begins at the following cycle and `done` drops.
- Result outputs change only at the FIXUP→DONE transition, the divide-by-zero transition, or reset.

## Test plan
- Unsigned divide, WIDTH=32: 100 / 7 with `signed_op`=0.
  - Required: `done` exactly 34 cycles after start, `quotient`=14, `remainder`=2, `div_by_zero`=0.
  - Required: `busy` high for 33 cycles.
- Signed divide: -7 / 2 with `signed_op`=1.
  - Required: `quotient`=0xFFFFFFFD (-3), `remainder`=0xFFFFFFFF (-1).
  - Also run 7 / -2. Required: `quotient`=-3, `remainder`=1.
- Divide by zero: 0x12345678 / 0.
  - Required: `done` at cycle T+1, `quotient`=0xFFFFFFFF, `remainder`=0x12345678, `div_by_zero`=1, `busy` never high.
- Signed overflow and unsigned extreme:
  - 0x80000000 / 0xFFFFFFFF signed. Required: `quotient`=0x80000000, `remainder`=0.
  - Same operands unsigned. Required: `quotient`=0, `remainder`=0x80000000.
- Handshake:
  - Pulse `start` with new operands at cycle T+10 of a running divide. Required: it is ignored and the first result is unchanged.
  - Assert `start` in the DONE cycle. Required: a second result follows 34 cycles later.
- Reset mid-operation: drive `rst_n`=0 at cycle T+15.
  - Required: all outputs are 0 at the next edge and `done` never pulses.
  - A new start after release completes normally.
